// File: rtl/round_referee_if.sv
//-----------------------------------------------------------------------------
// round_referee_if
//
// Purpose:
//   Groups the round referee's control inputs (start request, frame tick,
//   crash flags) and its round/score outputs into one bundle, so the referee,
//   the collision detector side and the scoreboard side share one port.
//
// Signals:
//   start       start request, level, already synchronised
//   tick        one-cycle frame-tick enable
//   crash_p1    player 1 collided (level)
//   crash_p2    player 2 collided (level)
//   run         high while the board may advance
//   board_clr   one-cycle pulse: wipe trails, respawn players
//   score_clr   one-cycle pulse: clear scoreboard
//   p1_win      one-cycle pulse: player 1 scores
//   p2_win      one-cycle pulse: player 2 scores
//   win_valid   high in the same cycle as any p1_win/p2_win pulse
//   draw        one-cycle pulse: both players crashed in the same cycle
//   match_over  level, high while the match is finished
//   winner      01 = player 1, 10 = player 2, 11 = both, 00 = none
//
// Modports:
//   master  the environment: drives the inputs, observes the outputs
//   slave   the referee: observes the inputs, drives the outputs
//-----------------------------------------------------------------------------
interface round_referee_if;

    logic       start;
    logic       tick;
    logic       crash_p1;
    logic       crash_p2;

    logic       run;
    logic       board_clr;
    logic       score_clr;
    logic       p1_win;
    logic       p2_win;
    logic       win_valid;
    logic       draw;
    logic       match_over;
    logic [1:0] winner;

    modport master (
        output start,
        output tick,
        output crash_p1,
        output crash_p2,
        input  run,
        input  board_clr,
        input  score_clr,
        input  p1_win,
        input  p2_win,
        input  win_valid,
        input  draw,
        input  match_over,
        input  winner
    );

    modport slave (
        input  start,
        input  tick,
        input  crash_p1,
        input  crash_p2,
        output run,
        output board_clr,
        output score_clr,
        output p1_win,
        output p2_win,
        output win_valid,
        output draw,
        output match_over,
        output winner
    );

endinterface

// File: rtl/round_referee.sv
//-----------------------------------------------------------------------------
// round_referee
//
// Purpose:
//   Match controller for the two-player light-cycle game. Watches the
//   collision detector's crash flags and sequences each round:
//     IDLE -> CLEAR -> COUNTDOWN -> RUN -> RESULT -> PAUSE -> CLEAR ...
//   until one shadow score reaches WIN_SCORE, then parks in OVER.
//   Emits the one-cycle win pulses / win_valid strobe the scoreboard counts,
//   plus the board-clear and score-clear strobes.
//
// Parameters:
//   WIN_SCORE        points that end the match (1..9)
//   COUNTDOWN_TICKS  frame ticks spent in COUNTDOWN (>= 1)
//   PAUSE_TICKS      frame ticks spent in PAUSE (>= 1)
//
// Ports:
//   clk    system clock, the only clock
//   reset  synchronous, active-high reset
//   bus    round_referee_if.slave: start/tick/crash inputs and all
//          round/score outputs (every output is registered)
//
// Configuration macro:
//   ROUND_REFEREE_DRAW_POINT_EN  when defined, a draw awards both players a
//                                point (p1_win, p2_win, win_valid and draw all
//                                pulse together); a simultaneous finish then
//                                reports winner = 11. Undefined: a draw only
//                                pulses draw and changes no score.
//
// Timing summary:
//   start seen at edge N (IDLE/OVER) -> score_clr high after N,
//   board_clr high after N+1 (COUNTDOWN entered at N+1).
//   Crash seen at RUN edge N -> run low and RESULT pulses high after N.
//   A tick sampled on the same edge that enters a state is not counted.
//-----------------------------------------------------------------------------
module round_referee #(
    parameter int unsigned WIN_SCORE       = 9,
    parameter int unsigned COUNTDOWN_TICKS = 180,
    parameter int unsigned PAUSE_TICKS     = 120
) (
    input logic            clk,
    input logic            reset,
    round_referee_if.slave bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLEAR     = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_RESULT    = 3'd4;
    localparam logic [2:0] ST_PAUSE     = 3'd5;
    localparam logic [2:0] ST_OVER      = 3'd6;

    // One tick counter serves both COUNTDOWN and PAUSE; size it for the
    // longer of the two.
    localparam int unsigned CNT_MAX = (COUNTDOWN_TICKS > PAUSE_TICKS) ?
                                      COUNTDOWN_TICKS : PAUSE_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] CD_LAST    = CNT_W'(COUNTDOWN_TICKS - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [3:0]       s1_q,         s1_d;
    logic [3:0]       s2_q,         s2_d;

    logic             run_q,        run_d;
    logic             board_clr_q,  board_clr_d;
    logic             score_clr_q,  score_clr_d;
    logic             p1_win_q,     p1_win_d;
    logic             p2_win_q,     p2_win_d;
    logic             win_valid_q,  win_valid_d;
    logic             draw_q,       draw_d;
    logic             match_over_q, match_over_d;
    logic [1:0]       winner_q,     winner_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Shadow scores stop at WIN_SCORE instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == WIN) ? s : s + 4'd1;
    endfunction

    // Winner code from the shadow scores; only meaningful once one of them
    // has reached WIN_SCORE.
    function automatic logic [1:0] winner_of(input logic [3:0] a,
                                             input logic [3:0] b);
        logic [1:0] w;
`ifdef ROUND_REFEREE_DRAW_POINT_EN
        // Both players can reach the target on the same scoring draw.
        w = {b == WIN, a == WIN};
`else
        // Only one score moves per round, so exactly one can be at target.
        w = (a == WIN) ? 2'b01 : 2'b10;
`endif
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal gets a default before the case so that no
        // path through the block leaves it unassigned (which would infer a
        // latch). Pulses and levels default low and are raised explicitly.
        state_d      = state_q;
        cnt_d        = cnt_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        run_d        = 1'b0;
        board_clr_d  = 1'b0;
        score_clr_d  = 1'b0;
        p1_win_d     = 1'b0;
        p2_win_d     = 1'b0;
        win_valid_d  = 1'b0;
        draw_d       = 1'b0;
        match_over_d = 1'b0;
        winner_d     = 2'b00;

        case (state_q)
            ST_IDLE: begin
                s1_d = 4'd0;
                s2_d = 4'd0;
                if (bus.start) begin
                    state_d     = ST_CLEAR;
                    score_clr_d = 1'b1;
                end
            end

            // One-cycle state: board_clr is registered on the way out, so it
            // lands in the cycle after score_clr.
            ST_CLEAR: begin
                board_clr_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_COUNTDOWN;
            end

            // Crash inputs are not looked at here.
            ST_COUNTDOWN: begin
                if (bus.tick) begin
                    if (cnt_q == CD_LAST) begin
                        state_d = ST_RUN;
                        run_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // The only state that samples the crash flags, so a crash level
            // held over from the previous round is simply not seen elsewhere.
            ST_RUN: begin
                run_d = 1'b1;
                if (bus.crash_p1 || bus.crash_p2) begin
                    state_d = ST_RESULT;
                    run_d   = 1'b0;
                    if (bus.crash_p1 && bus.crash_p2) begin
                        draw_d = 1'b1;
`ifdef ROUND_REFEREE_DRAW_POINT_EN
                        p1_win_d    = 1'b1;
                        p2_win_d    = 1'b1;
                        win_valid_d = 1'b1;
                        s1_d        = sat_inc(s1_q);
                        s2_d        = sat_inc(s2_q);
`endif
                    end else if (bus.crash_p1) begin
                        // Player 1 crashed into something: player 2 scores.
                        p2_win_d    = 1'b1;
                        win_valid_d = 1'b1;
                        s2_d        = sat_inc(s2_q);
                    end else begin
                        p1_win_d    = 1'b1;
                        win_valid_d = 1'b1;
                        s1_d        = sat_inc(s1_q);
                    end
                end
            end

            // The round's pulses are already on the outputs during this cycle.
            ST_RESULT: begin
                cnt_d   = '0;
                state_d = ST_PAUSE;
            end

            ST_PAUSE: begin
                if (bus.tick) begin
                    if (cnt_q == PAUSE_LAST) begin
                        if ((s1_q == WIN) || (s2_q == WIN)) begin
                            state_d      = ST_OVER;
                            match_over_d = 1'b1;
                            winner_d     = winner_of(s1_q, s2_q);
                        end else begin
                            state_d = ST_CLEAR;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_OVER: begin
                match_over_d = 1'b1;
                winner_d     = winner_of(s1_q, s2_q);
                if (bus.start) begin
                    state_d      = ST_CLEAR;
                    score_clr_d  = 1'b1;
                    match_over_d = 1'b0;
                    winner_d     = 2'b00;
                    s1_d         = 4'd0;
                    s2_d         = 4'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before the edge, independent of statement order.
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s1_q         <= 4'd0;
            s2_q         <= 4'd0;
            run_q        <= 1'b0;
            board_clr_q  <= 1'b0;
            score_clr_q  <= 1'b0;
            p1_win_q     <= 1'b0;
            p2_win_q     <= 1'b0;
            win_valid_q  <= 1'b0;
            draw_q       <= 1'b0;
            match_over_q <= 1'b0;
            winner_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            run_q        <= run_d;
            board_clr_q  <= board_clr_d;
            score_clr_q  <= score_clr_d;
            p1_win_q     <= p1_win_d;
            p2_win_q     <= p2_win_d;
            win_valid_q  <= win_valid_d;
            draw_q       <= draw_d;
            match_over_q <= match_over_d;
            winner_q     <= winner_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.run        = run_q;
    assign bus.board_clr  = board_clr_q;
    assign bus.score_clr  = score_clr_q;
    assign bus.p1_win     = p1_win_q;
    assign bus.p2_win     = p2_win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.draw       = draw_q;
    assign bus.match_over = match_over_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_round_referee.sv
//-----------------------------------------------------------------------------
// tb_round_referee
//
// Bench for round_referee with WIN_SCORE=2, COUNTDOWN_TICKS=3, PAUSE_TICKS=2.
// A procedural match model (a thread walking through rounds, waiting on
// sampled ticks and crashes) predicts every output for every cycle; a compare
// process checks the DUT against it on each falling edge. Directed stimulus
// adds hand-computed literal checks at the key moments.
//-----------------------------------------------------------------------------
module tb_round_referee;

    localparam int WIN = 2;
    localparam int CD  = 3;
    localparam int PT  = 2;

    logic clk;
    logic reset;

    round_referee_if bus ();

    round_referee #(
        .WIN_SCORE      (WIN),
        .COUNTDOWN_TICKS(CD),
        .PAUSE_TICKS    (PT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check2(input string name, input logic [1:0] act,
                          input logic [1:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Tick generator: every cycle, or every third cycle in sparse mode
    // ------------------------------------------------------------------
    bit tick_all = 1'b1;
    int cyc_n    = 0;

    initial begin
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc_n++;
            bus.tick = tick_all ? 1'b1 : ((cyc_n % 3) == 0);
        end
    end

    // ------------------------------------------------------------------
    // Match model
    // ------------------------------------------------------------------
    logic       e_run, e_bclr, e_sclr, e_p1, e_p2, e_wv, e_draw, e_over;
    logic [1:0] e_win;
    int         m_s1, m_s2;
    bit         m_rst, m_start, m_tick, m_c1, m_c2;

    // Wait for the next edge, capture what the DUT sees there, and start
    // from "everything low" for the cycle that follows.
    task automatic adv();
        @(posedge clk);
        m_rst   = reset;
        m_start = bus.start;
        m_tick  = bus.tick;
        m_c1    = bus.crash_p1;
        m_c2    = bus.crash_p2;
        {e_run, e_bclr, e_sclr, e_p1, e_p2, e_wv, e_draw, e_over} = '0;
        e_win = 2'b00;
    endtask

    // Plays matches from idle; returns as soon as a reset is seen.
    task automatic play();
        int n;
        do adv(); while (m_rst || !m_start);
        forever begin
            m_s1 = 0;
            m_s2 = 0;
            e_sclr = 1'b1;
            forever begin
                adv(); if (m_rst) return;
                e_bclr = 1'b1;
                n = 0;
                while (n < CD) begin
                    adv(); if (m_rst) return;
                    if (m_tick) n++;
                end
                e_run = 1'b1;
                forever begin
                    adv(); if (m_rst) return;
                    if (m_c1 || m_c2) break;
                    e_run = 1'b1;
                end
                if (m_c1 && m_c2) begin
                    e_draw = 1'b1;
`ifdef ROUND_REFEREE_DRAW_POINT_EN
                    e_p1 = 1'b1; e_p2 = 1'b1; e_wv = 1'b1;
                    if (m_s1 < WIN) m_s1++;
                    if (m_s2 < WIN) m_s2++;
`endif
                end else if (m_c1) begin
                    e_p2 = 1'b1; e_wv = 1'b1;
                    if (m_s2 < WIN) m_s2++;
                end else begin
                    e_p1 = 1'b1; e_wv = 1'b1;
                    if (m_s1 < WIN) m_s1++;
                end
                adv(); if (m_rst) return;   // RESULT cycle ends, pause begins
                n = 0;
                while (n < PT) begin
                    adv(); if (m_rst) return;
                    if (m_tick) n++;
                end
                if (m_s1 == WIN || m_s2 == WIN) break;
            end
            forever begin
                e_over = 1'b1;
                if (m_s1 == WIN && m_s2 == WIN) e_win = 2'b11;
                else if (m_s1 == WIN)           e_win = 2'b01;
                else                            e_win = 2'b10;
                adv(); if (m_rst) return;
                if (m_start) break;
            end
        end
    endtask

    initial begin
        {e_run, e_bclr, e_sclr, e_p1, e_p2, e_wv, e_draw, e_over} = '0;
        e_win = 2'b00;
        forever play();
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check1("m_run",        bus.run,        e_run);
                check1("m_board_clr",  bus.board_clr,  e_bclr);
                check1("m_score_clr",  bus.score_clr,  e_sclr);
                check1("m_p1_win",     bus.p1_win,     e_p1);
                check1("m_p2_win",     bus.p2_win,     e_p2);
                check1("m_win_valid",  bus.win_valid,  e_wv);
                check1("m_draw",       bus.draw,       e_draw);
                check1("m_match_over", bus.match_over, e_over);
                check2("m_winner",     bus.winner,     e_win);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic check_all_zero(input string tag);
        check1({tag, "_run"},        bus.run,        1'b0);
        check1({tag, "_board_clr"},  bus.board_clr,  1'b0);
        check1({tag, "_score_clr"},  bus.score_clr,  1'b0);
        check1({tag, "_p1_win"},     bus.p1_win,     1'b0);
        check1({tag, "_p2_win"},     bus.p2_win,     1'b0);
        check1({tag, "_win_valid"},  bus.win_valid,  1'b0);
        check1({tag, "_draw"},       bus.draw,       1'b0);
        check1({tag, "_match_over"}, bus.match_over, 1'b0);
        check2({tag, "_winner"},     bus.winner,     2'b00);
    endtask

    // Start pulse from IDLE or OVER with ticks every cycle; a one-cycle
    // crash is injected during the countdown and must be ignored.
    // Leaves the bench on the falling edge where run has just risen.
    task automatic start_and_check();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check1("sclr_pulse", bus.score_clr, 1'b1);
        check1("sclr_model", e_sclr,        1'b1);
        check1("bclr_early", bus.board_clr, 1'b0);
        @(negedge clk);
        check1("bclr_pulse", bus.board_clr, 1'b1);
        check1("sclr_once",  bus.score_clr, 1'b0);
        @(negedge clk);
        check1("run_cd1", bus.run, 1'b0);
        bus.crash_p1 = 1'b1;
        @(negedge clk);
        check1("run_cd2",  bus.run,    1'b0);
        check1("cd_crash", bus.p2_win, 1'b0);
        bus.crash_p1 = 1'b0;
        @(negedge clk);
        check1("run_up",       bus.run, 1'b1);
        check1("run_up_model", e_run,   1'b1);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.run) break;
        end
        check1("run_reached", bus.run, 1'b1);
    endtask

    // Player 2 crashes: player 1 takes the round.
    task automatic p1_round();
        wait_run();
        bus.crash_p2 = 1'b1;
        @(negedge clk);
        check1("p1r_p1_win", bus.p1_win,    1'b1);
        check1("p1r_wv",     bus.win_valid, 1'b1);
        check1("p1r_p2_win", bus.p2_win,    1'b0);
        bus.crash_p2 = 1'b0;
    endtask

    task automatic draw_round();
        wait_run();
        bus.crash_p1 = 1'b1;
        bus.crash_p2 = 1'b1;
        @(negedge clk);
        check1("draw_pulse", bus.draw, 1'b1);
        check1("draw_run",   bus.run,  1'b0);
`ifdef ROUND_REFEREE_DRAW_POINT_EN
        check1("draw_p1", bus.p1_win,    1'b1);
        check1("draw_p2", bus.p2_win,    1'b1);
        check1("draw_wv", bus.win_valid, 1'b1);
`else
        check1("draw_p1", bus.p1_win,    1'b0);
        check1("draw_p2", bus.p2_win,    1'b0);
        check1("draw_wv", bus.win_valid, 1'b0);
`endif
        bus.crash_p1 = 1'b0;
        bus.crash_p2 = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.crash_p1 = 1'b0;
        bus.crash_p2 = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        chk_en = 1'b1;
        reset  = 1'b0;

        // Match 1: first round, start ignored in RUN, player 1 crash held
        // across RESULT and PAUSE.
        start_and_check();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check1("start_in_run", bus.run, 1'b1);
        check1("start_no_clr", bus.score_clr, 1'b0);
        bus.crash_p1 = 1'b1;
        @(negedge clk);
        check1("c1_p2_win", bus.p2_win,    1'b1);
        check1("c1_wv",     bus.win_valid, 1'b1);
        check1("c1_p1_win", bus.p1_win,    1'b0);
        check1("c1_run",    bus.run,       1'b0);
        @(negedge clk);
        check1("c1_once", bus.p2_win, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check1("pause_bclr_early", bus.board_clr, 1'b0);
        bus.crash_p1 = 1'b0;
        @(negedge clk);
        check1("pause_bclr", bus.board_clr, 1'b1);

        // Player 1 takes two rounds and the match.
        p1_round();
        p1_round();
        @(negedge clk);
        @(negedge clk);
        check1("over_early", bus.match_over, 1'b0);
        @(negedge clk);
        check1("over_level",  bus.match_over, 1'b1);
        check2("over_winner", bus.winner,     2'b01);
        check2("over_model",  e_win,          2'b01);
        repeat (3) @(negedge clk);
        check1("over_holds", bus.match_over, 1'b1);

        // Restart from OVER, then a draw round.
        start_and_check();
        check1("restart_over_clr", bus.match_over, 1'b0);
        draw_round();

        // Reset in the middle of RUN.
        wait_run();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start_and_check();

        // Sparse ticks: two draws in a row (a scoring draw ends the match
        // with both players at target).
        tick_all = 1'b0;
        draw_round();
        draw_round();
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_referee.md
# round_referee

Match controller for the two-player light-cycle game. Sits directly upstream of the score display block: it watches the collision detector's crash flags, sequences each round (clear, countdown, run, result, pause), and emits the one-cycle win pulses and win-valid strobe that the scoreboard counts. It keeps its own shadow score to declare match over at a target score, and issues the board-clear and score-clear strobes.

## Interface

Parameters:
- WIN_SCORE, default 9: points that end the match. Range 1..9, because the display shows one decimal digit.
- COUNTDOWN_TICKS, default 180: frame ticks spent in COUNTDOWN. Must be ≥1.
- PAUSE_TICKS, default 120: frame ticks spent in PAUSE. Must be ≥1.

Ports:
- clk  in  1  system clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start request, level, already synchronised
- tick  in  1  one-cycle frame-tick enable
- crash_p1  in  1  player 1 collided (level from collision detector)
- crash_p2  in  1  player 2 collided
- run  out  1  high while the board may advance
- board_clr  out  1  one-cycle pulse: wipe trails, respawn players
- score_clr  out  1  one-cycle pulse: clear scoreboard (integration inverts it for an active-low clear)
- p1_win  out  1  one-cycle pulse: player 1 scores
- p2_win  out  1  one-cycle pulse: player 2 scores
- win_valid  out  1  high in the same cycle as any p1_win/p2_win pulse
- draw  out  1  one-cycle pulse: both crashed in the same cycle
- match_over  out  1  level, high in OVER
- winner  out  2  01 = player 1, 10 = player 2, 00 = none. Valid in OVER, otherwise 00.

## Operation

- States: IDLE, CLEAR, COUNTDOWN, RUN, RESULT, PAUSE, OVER.
- IDLE: all outputs 0.
  - start=1 → CLEAR, and score_clr pulses on that transition cycle.
  - Shadow scores s1 and s2 (4-bit each) are set to 0.
- CLEAR: board_clr=1 for exactly one cycle, then COUNTDOWN.
- COUNTDOWN:
  - A tick counter counts tick pulses. After COUNTDOWN_TICKS ticks, go to RUN.
  - The counter is zeroed on entry.
  - Crash inputs are ignored.
- RUN:
  - run=1.
  - crash_p1 & ~crash_p2 → player 2 wins the round.
  - crash_p2 & ~crash_p1 → player 1 wins the round.
  - Both crash in the same cycle → draw.
  - Any crash → RESULT.
- RESULT (one cycle):
  - Player 1 round: p1_win=1, win_valid=1, s1+=1.
  - Player 2 round: p2_win=1, win_valid=1, s2+=1.
  - Draw: draw=1, no score change.
  - Next state is PAUSE.
- PAUSE:
  - Waits PAUSE_TICKS ticks.
  - Then, if s1==WIN_SCORE or s2==WIN_SCORE → OVER; otherwise → CLEAR.
- OVER:
  - match_over=1; winner reflects whichever score reached WIN_SCORE.
  - start=1 → CLEAR, with score_clr pulsing on the transition cycle and s1/s2 zeroed.
- start is ignored in all states other than IDLE and OVER.
- Shadow scores saturate at WIN_SCORE; they never wrap.

## Timing

- All outputs are registered, and all are 0 on the cycle after reset is sampled high. Reset overrides everything.
- Reset mid-round: state → IDLE, s1/s2/tick counter → 0, no pulses emitted.
- Crash sampled at RUN edge N:
  - run drops after edge N.
  - The RESULT pulses are high for the single cycle between edges N and N+1.
- start sampled at edge N in IDLE or OVER:
  - score_clr is high after edge N for one cycle.
  - board_clr is high in the following cycle.
- tick coincident with a state entry does not count toward that state.
- A crash level held across states produces only one RESULT per round. It must be low, or it is ignored, until RUN is re-entered; it is re-sampled only in RUN.
- Latency from start to run, assuming tick is present: 2 + COUNTDOWN_TICKS ticks.

## Configuration

- Macro: ROUND_REFEREE_DRAW_POINT_EN.
- Defined: a draw in RESULT awards both players a point.
  - p1_win=1, p2_win=1, win_valid=1 and draw=1 in the same cycle.
  - s1 and s2 both increment.
  - If both scores reach WIN_SCORE together, OVER is entered with winner=11.
- Undefined: a draw awards nothing and winner=11 is never produced.

## Test plan

- Reset, start=1 for one cycle → score_clr high one cycle, then board_clr one cycle; run rises after COUNTDOWN_TICKS ticks (use COUNTDOWN_TICKS=3).
- In RUN, crash_p1=1 → next cycle p2_win=1, win_valid=1, p1_win=0; run=0; after PAUSE_TICKS ticks, board_clr pulses.
- In RUN, crash_p1=crash_p2=1 in the same cycle → draw=1, win_valid=0 (macro off); with macro on → p1_win=p2_win=win_valid=draw=1.
- WIN_SCORE=2, player 1 wins two rounds → match_over=1, winner=01 after the second PAUSE; start → score_clr and a new round.
- Crash during COUNTDOWN and start during RUN → no effect on pulses or state.
- reset asserted mid-RUN → all outputs 0 next cycle; a later start behaves exactly as from power-up.
